slide_enhance_prep: RTL
=======================

SLIDE_ENHANCE_PREP -- requirements
Module: slide_enhance_prep

Interface
REQ-001 The block SHALL have a single clock, i_clk; reset i_rst SHALL be synchronous and active-high.
REQ-002 The block SHALL have these parameters:
- C_AVG_SHIFT, default 21, right-shift that turns the frame luma sum into the mean (2^21 ≈ 1920x1080).
- C_GAIN_STEP, default 4, maximum gain change per frame.
- C_GAIN_INIT, default 0, gain value after reset.
REQ-003 The block SHALL have these ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_vid_vde  in  1  pixel valid.
- i_vid_hsync  in  1  line sync.
- i_vid_vsync  in  1  frame sync; 1->0 marks frame start.
- i_vid_data  in  24  RGB888 pixel.
- o_vid_vde / o_vid_hsync / o_vid_vsync  out  1 each  input controls delayed by 3 cycles.
- o_vid_data1  out  24  original pixel delayed by 3 cycles (feeds slide video 1).
- o_vid_data2  out  24  dark-enhanced pixel (feeds slide video 2).
- o_mean_luma  out  8  mean luma of the last completed frame.
- o_gain  out  8  current curve gain.

Function
REQ-004 Latency: every output video signal SHALL equal the corresponding input from exactly 3 cycles earlier, with a fixed 3-stage pipeline and no stalls.
REQ-005 Luma: Y = (77*R + 150*G + 29*B) >> 8, unsigned, 8 bits.
REQ-006 Accumulation:
- Y SHALL be added to a 32-bit sum on each cycle with i_vid_vde=1, in every state except ST_WAIT.
- The sum SHALL saturate at 0xFFFFFFFF.
REQ-007 Frame start: a vsync falling edge is i_vid_vsync=0 with the previous registered i_vid_vsync=1.
REQ-008 FSM states are ST_WAIT, ST_ACCUM, ST_CALC and ST_SMOOTH; reset state is ST_WAIT.
REQ-009 ST_WAIT -> ST_ACCUM on a vsync fall; the sum SHALL be cleared and the gain left unchanged, because no complete frame exists yet.
REQ-010 On a vsync fall in ST_ACCUM, in the same cycle the block SHALL:
- latch the sum into the stats register;
- clear the sum, so the new frame accumulates from that edge;
- go to ST_CALC.
REQ-011 ST_CALC (1 cycle):
- mean = min(stats >> C_AVG_SHIFT, 255), registered to o_mean_luma;
- target = min(2*(128-mean), 255) if mean < 128, else 0;
- next state ST_SMOOTH.
REQ-012 ST_SMOOTH (1 cycle): gain moves toward target by at most C_GAIN_STEP, landing exactly on target if closer, never outside 0..255; then ST_ACCUM.
REQ-013 A vsync fall seen in ST_CALC or ST_SMOOTH SHALL be ignored: no latch and no sum clear.
REQ-014 Gain SHALL change only in ST_SMOOTH.
REQ-015 Curve (per channel, x 8-bit):
- Stage 1: d = x*(255-x), 16 bits.
- Stage 2: e = (d*gain) >> 14, using the gain value present in stage 2.
- Stage 3: out = min(x+e, 255).
REQ-016 With gain=0, o_vid_data2 SHALL equal o_vid_data1 bit-exactly; x=0 and x=255 SHALL pass through unchanged for any gain.
REQ-017 o_vid_data1/2 SHALL hold their last value while the delayed vde is 0.

Reset
REQ-018 While i_rst=1 at a clock edge:
- all outputs SHALL be set to 0, except o_gain = C_GAIN_INIT;
- sum, stats and pipeline SHALL be cleared;
- state SHALL go to ST_WAIT.
REQ-019 Reset mid-frame SHALL discard the partial sum; the first full frame after the next vsync fall is the first one used.

Verification (test params C_AVG_SHIFT=6, 16x4-pixel frames, C_GAIN_STEP=16)
REQ-020 Hold i_rst high for 2 cycles -> all outputs 0, o_gain=0, no gain update on the first vsync fall.
REQ-021 Frames of constant 0x202020 (Y=32) -> o_mean_luma=32, target=192, o_gain = 16, 32, 48 ... after successive frames, saturating at 192.
REQ-022 Gain forced to 255, pixel 0x80_00_FF -> o_vid_data2 = 0xFF_00_FF, 3 cycles later.
REQ-023 Gain=0, random pixels and syncs -> o_vid_data2 == o_vid_data1 == input delayed 3 cycles; controls also delayed 3 cycles.
REQ-024 Gain=40, then frames of constant 0xC8C8C8 (mean 200) -> gain 24, 8, 0, 0.
REQ-025 Assert i_rst mid-frame, then release -> state ST_WAIT, gain=C_GAIN_INIT; the next vsync fall causes no gain change.

Source files
------------

// File: rtl/slide_enhance_prep.sv
// Luma-mean driven dark-enhance curve with original/enhanced slide outputs; fixed 3-cycle video latency.
// No backpressure: every input cycle is accepted and emerges 3 cycles later; gain adapts once per frame.
module slide_enhance_prep #(
    parameter int C_AVG_SHIFT = 21,
    parameter int C_GAIN_STEP = 4,
    parameter int C_GAIN_INIT = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_vid_vde,
    input  logic        i_vid_hsync,
    input  logic        i_vid_vsync,
    input  logic [23:0] i_vid_data,
    output logic        o_vid_vde,
    output logic        o_vid_hsync,
    output logic        o_vid_vsync,
    output logic [23:0] o_vid_data1,
    output logic [23:0] o_vid_data2,
    output logic [7:0]  o_mean_luma,
    output logic [7:0]  o_gain
);

    typedef enum logic [1:0] {ST_WAIT, ST_ACCUM, ST_CALC, ST_SMOOTH} state_t;

    localparam logic [7:0] GAIN_INIT = 8'(C_GAIN_INIT);
    localparam logic [8:0] GAIN_STEP = 9'(C_GAIN_STEP);

    state_t      state;
    logic        vs_q;
    logic [31:0] sum;
    logic [31:0] stats;
    logic [7:0]  target;
    logic [7:0]  gain;
    logic [7:0]  mean;

    logic        vs_fall;
    logic [15:0] luma_full;
    logic [7:0]  luma;
    logic [32:0] sum_wide;
    logic [31:0] sum_acc;
    logic [31:0] mean_wide;
    logic [7:0]  mean_calc;
    logic [9:0]  dbl;
    logic [7:0]  target_calc;
    logic [7:0]  diff;
    logic [7:0]  gain_next;

    // Pipeline registers
    logic        s1_vde, s1_hs, s1_vs;
    logic [23:0] s1_x;
    logic [2:0][15:0] s1_d;
    logic        s2_vde, s2_hs, s2_vs;
    logic [23:0] s2_x;
    logic [2:0][9:0]  s2_e;

    logic [2:0][15:0] d_c;
    logic [2:0][23:0] prod_c;
    logic [2:0][9:0]  e_c;
    logic [2:0][10:0] sat_c;
    logic [2:0][7:0]  y_c;

    assign vs_fall   = vs_q & ~i_vid_vsync;
    assign luma_full = 16'd77  * 16'(i_vid_data[23:16])
                     + 16'd150 * 16'(i_vid_data[15:8])
                     + 16'd29  * 16'(i_vid_data[7:0]);
    assign luma      = 8'(luma_full >> 8);
    assign sum_wide  = {1'b0, sum} + 33'(luma);
    assign sum_acc   = !i_vid_vde ? sum : (sum_wide[32] ? 32'hFFFF_FFFF : sum_wide[31:0]);

    always_comb begin
        mean_wide   = stats >> C_AVG_SHIFT;
        mean_calc   = (mean_wide > 32'd255) ? 8'd255 : mean_wide[7:0];
        dbl         = (10'd128 - 10'(mean_calc)) << 1;
        target_calc = 8'd0;
        if (mean_calc < 8'd128)
            target_calc = (dbl > 10'd255) ? 8'd255 : dbl[7:0];
    end

    // Step toward target, snapping onto it when within one step.
    always_comb begin
        diff      = 8'd0;
        gain_next = gain;
        if (target > gain) begin
            diff      = target - gain;
            gain_next = ({1'b0, diff} > GAIN_STEP) ? gain + 8'(GAIN_STEP) : target;
        end else if (target < gain) begin
            diff      = gain - target;
            gain_next = ({1'b0, diff} > GAIN_STEP) ? gain - 8'(GAIN_STEP) : target;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= ST_WAIT;
            vs_q   <= 1'b0;
            sum    <= '0;
            stats  <= '0;
            target <= '0;
            mean   <= '0;
            gain   <= GAIN_INIT;
        end else begin
            vs_q <= i_vid_vsync;
            case (state)
                ST_WAIT: begin
                    if (vs_fall) begin
                        sum   <= '0;
                        state <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (vs_fall) begin
                        stats <= sum;
                        sum   <= i_vid_vde ? 32'(luma) : 32'd0;
                        state <= ST_CALC;
                    end else begin
                        sum <= sum_acc;
                    end
                end
                ST_CALC: begin
                    sum    <= sum_acc;
                    mean   <= mean_calc;
                    target <= target_calc;
                    state  <= ST_SMOOTH;
                end
                default: begin
                    sum   <= sum_acc;
                    gain  <= gain_next;
                    state <= ST_ACCUM;
                end
            endcase
        end
    end

    // Curve: x + (x*(255-x)*gain >> 14), clamped at 255 per channel.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            d_c[c]    = 16'(i_vid_data[8*c +: 8]) * 16'(8'd255 - i_vid_data[8*c +: 8]);
            prod_c[c] = 24'(s1_d[c]) * 24'(gain);
            e_c[c]    = 10'(prod_c[c] >> 14);
            sat_c[c]  = 11'(s2_x[8*c +: 8]) + 11'(s2_e[c]);
            y_c[c]    = (sat_c[c] > 11'd255) ? 8'hFF : sat_c[c][7:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_vde      <= 1'b0;
            s1_hs       <= 1'b0;
            s1_vs       <= 1'b0;
            s1_x        <= '0;
            s1_d        <= '0;
            s2_vde      <= 1'b0;
            s2_hs       <= 1'b0;
            s2_vs       <= 1'b0;
            s2_x        <= '0;
            s2_e        <= '0;
            o_vid_vde   <= 1'b0;
            o_vid_hsync <= 1'b0;
            o_vid_vsync <= 1'b0;
            o_vid_data1 <= '0;
            o_vid_data2 <= '0;
        end else begin
            s1_vde      <= i_vid_vde;
            s1_hs       <= i_vid_hsync;
            s1_vs       <= i_vid_vsync;
            s1_x        <= i_vid_data;
            s1_d        <= d_c;
            s2_vde      <= s1_vde;
            s2_hs       <= s1_hs;
            s2_vs       <= s1_vs;
            s2_x        <= s1_x;
            s2_e        <= e_c;
            o_vid_vde   <= s2_vde;
            o_vid_hsync <= s2_hs;
            o_vid_vsync <= s2_vs;
            if (s2_vde) begin
                o_vid_data1 <= s2_x;
                o_vid_data2 <= y_c;
            end
        end
    end

    assign o_mean_luma = mean;
    assign o_gain      = gain;

endmodule
